// File: rtl/corr_mult_stage.sv
// Complex correlation multiplier: Re(A*conj(B)) per sample, framed by an
// IDLE/RUN controller feeding a 3-stage pipeline into the accumulator.
module corr_mult_stage #(
    parameter int FRAME_LEN = 1024,
    parameter int SHIFT     = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic [15:0] i_a_re,
    input  logic [15:0] i_a_im,
    input  logic [15:0] i_b_re,
    input  logic [15:0] i_b_im,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_err,
    output logic [15:0] o_frames
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic signed [32:0] SAT_MAX = 33'sd16777215;
    localparam logic signed [32:0] SAT_MIN = -33'sd16777216;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        started, started_nx;
    logic        err_nx;
    logic        accept;
    logic        last_in;

    logic               s1_v, s1_last;
    logic signed [15:0] a_re, a_im, b_re, b_im;
    logic               s2_v, s2_last;
    logic signed [31:0] p_re, p_im;

    logic signed [32:0] sum;
    logic signed [32:0] shd;
    logic signed [24:0] sat;

    // A gap is only an abort once the frame has actually begun.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        started_nx = started;
        err_nx     = o_err;
        accept     = 1'b0;
        last_in    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx   = RUN;
                    cnt_nx     = '0;
                    started_nx = 1'b0;
                    err_nx     = 1'b0;
                end
            end
            RUN: begin
                if (i_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST_IDX) begin
                        last_in    = 1'b1;
                        state_nx   = IDLE;
                        cnt_nx     = '0;
                        started_nx = 1'b0;
                    end else begin
                        cnt_nx     = cnt + 16'd1;
                        started_nx = 1'b1;
                    end
                end else if (started) begin
                    state_nx   = IDLE;
                    err_nx     = 1'b1;
                    cnt_nx     = '0;
                    started_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sum = 33'(p_re) + 33'(p_im);
    assign shd = sum >>> SHIFT;

    always_comb begin
        sat = shd[24:0];
        if (shd > SAT_MAX) begin
            sat = 25'h0FF_FFFF;
        end else if (shd < SAT_MIN) begin
            sat = 25'h100_0000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            started  <= 1'b0;
            o_err    <= 1'b0;
            s1_v     <= 1'b0;
            s1_last  <= 1'b0;
            a_re     <= '0;
            a_im     <= '0;
            b_re     <= '0;
            b_im     <= '0;
            s2_v     <= 1'b0;
            s2_last  <= 1'b0;
            p_re     <= '0;
            p_im     <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_data   <= '0;
            o_frames <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            started <= started_nx;
            o_err   <= err_nx;

            s1_v    <= accept;
            s1_last <= last_in;
            if (accept) begin
                a_re <= i_a_re;
                a_im <= i_a_im;
                b_re <= i_b_re;
                b_im <= i_b_im;
            end

            s2_v    <= s1_v;
            s2_last <= s1_v & s1_last;
            p_re    <= 32'(a_re) * 32'(b_re);
            p_im    <= 32'(a_im) * 32'(b_im);

            o_valid <= s2_v;
            o_last  <= s2_v & s2_last;
            o_data  <= s2_v ? {{7{sat[24]}}, sat} : 32'd0;
            if (s2_v && s2_last) begin
                o_frames <= o_frames + 16'd1;
            end
        end
    end

    assign o_busy = (state == RUN) | s1_v | s2_v | o_valid;

endmodule
